// File: rtl/crc3_checker.sv
// Serial CRC-3 checker (g(x) = x^3 + x + 1): MSB-first codewords, reports message, syndrome, pass flag.
// Optional saturating failed-frame counter on err_count when CRC3_CHECKER_ERRCNT_EN is defined.
module crc3_checker #(
  parameter int                MSG_W = 5,
  parameter int                CRC_W = 3,
  parameter logic [CRC_W-1:0]  POLY  = 3'b011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             frame_valid,
  output logic [MSG_W-1:0] msg_out,
  output logic [CRC_W-1:0] syndrome,
  output logic             crc_ok,
  output logic             busy
`ifdef CRC3_CHECKER_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int FRAME_W = MSG_W + CRC_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CRC_W-1:0]   r_rem;
  logic [CRC_W-1:0]   w_rem_nxt;
  logic [MSG_W-1:0]   r_msg_sr;
  logic               w_accept;
  logic               w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    frame_valid = 1'b0;
    busy        = 1'b0;
    w_last      = 1'b0;
    w_accept    = bit_valid & ~clear;
    w_rem_nxt   = {r_rem[CRC_W-2:0], bit_in} ^ (r_rem[CRC_W-1] ? POLY : '0);
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = RECV;
      end
      RECV: begin
        busy = 1'b1;
        if (w_accept && r_cnt == CNT_W'(FRAME_W - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = REPORT;
        end
      end
      REPORT: begin
        frame_valid = ~clear;
        w_state_nxt = w_accept ? RECV : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  // Working registers are zeroed on frame completion so a bit accepted in REPORT starts from scratch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_msg_sr <= '0;
      msg_out  <= '0;
      syndrome <= '0;
      crc_ok   <= 1'b0;
    end else if (clear) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_msg_sr <= '0;
    end else if (w_last) begin
      msg_out  <= r_msg_sr;
      syndrome <= w_rem_nxt;
      crc_ok   <= (w_rem_nxt == '0);
      r_cnt    <= '0;
      r_rem    <= '0;
      r_msg_sr <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_rem_nxt;
      if (r_cnt < CNT_W'(MSG_W)) r_msg_sr <= {r_msg_sr[MSG_W-2:0], bit_in};
    end
  end

`ifdef CRC3_CHECKER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 8'h00;
    else if (r_state == REPORT && !crc_ok && err_count != 8'hFF)
      err_count <= err_count + 8'h01;
  end
`endif

endmodule

// File: doc/crc3_checker.md
Name: crc3_checker

Overview:
- Receive-side companion to the serial CRC-3 encoder. Same generator, g(x) = x^3 + x + 1.
- Takes a serial codeword MSB-first: 5 message bits, then 3 CRC bits, 8 bits per frame.
- Computes the division remainder (syndrome) on the fly.
- After the last bit of each frame, reports the recovered message, the syndrome and a pass/fail flag.

Parameters:
- MSG_W, 5: message bits per frame.
- CRC_W, 3: CRC bits per frame; frame length FRAME_W = MSG_W + CRC_W = 8.
- POLY, 3'b011: generator taps. These are the low CRC_W bits of g(x); the x^3 term is implicit.

Ports:
- clk, input, 1: single clock; everything is rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- bit_in, input, 1: serial codeword bit, MSB-first.
- bit_valid, input, 1: bit_in is sampled on a rising edge only when this is 1.
- clear, input, 1: synchronous frame abort.
- frame_valid, output, 1: one-cycle pulse, asserted the cycle after the last bit of a frame is accepted.
- msg_out, output, MSG_W: message bits of the last completed frame.
- syndrome, output, CRC_W: remainder of the last completed frame.
- crc_ok, output, 1: 1 when syndrome == 0.
- busy, output, 1: 1 while a frame is partially received.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, bit counter = 0, running remainder = 0, message shift register = 0.
  - Outputs: frame_valid = 0, msg_out = 0, syndrome = 0, crc_ok = 0, busy = 0.
  - Reset mid-frame discards the partial frame.
- Remainder update, on each accepted bit:
  - fb = r[CRC_W-1].
  - r <= {r[CRC_W-2:0], bit_in} ^ (fb ? POLY : 0).
  - After all FRAME_W bits, r = codeword mod g(x).
- Message capture: the first MSG_W accepted bits shift into msg_sr MSB-first. CRC bits are not stored.
- FSM states: IDLE, RECV, REPORT.
  - IDLE: busy = 0. On bit_valid, accept bit 0 (count = 1, r and msg_sr updated from zero) and go to RECV.
  - RECV: busy = 1. Each bit_valid accepts one bit and increments the count. Gaps (bit_valid = 0) hold all state indefinitely. When bit FRAME_W-1 is accepted, latch the final r into syndrome, msg_sr into msg_out, crc_ok = (final r == 0), then go to REPORT.
  - REPORT: lasts exactly one cycle. frame_valid = 1, busy = 0. A bit_valid in this cycle is accepted as bit 0 of the next frame (count = 1, go to RECV). Otherwise go to IDLE. Back-to-back frames therefore need no idle gap.
- Output holding: msg_out, syndrome and crc_ok hold their values until the next frame completes.
- Latency: frame_valid and the updated outputs appear one cycle after the edge that accepts the final bit.
- clear:
  - Any state goes to IDLE; count and r are zeroed, msg_sr is cleared.
  - Reported outputs are retained.
  - clear suppresses frame_valid if the FSM is in REPORT.
  - clear together with bit_valid: clear wins and the bit is dropped.
  - clear coincident with acceptance of the final bit: the frame is discarded and nothing is reported.
- Aliasing: g(x) has period 7, so an error at bit 0 (the MSB) and an error at bit 7 (the LSB) give the same syndrome, 3'b001. The block only detects errors; it never attempts correction.

Optional Feature:
- Macro: CRC3_CHECKER_ERRCNT_EN.
- When defined:
  - Adds output port err_count, 8 bits.
  - It is a saturating count of completed frames with crc_ok = 0, incremented in the REPORT cycle of each failing frame.
  - It holds at 8'hFF.
  - Cleared only by rst_n; clear does not affect it.
- When undefined: the port and its register are absent, and all other behaviour is identical.

Test Plan:
- Serial 1,0,1,0,1,1,0,1 (8'hAD) with bit_valid held high -> 1 cycle later: frame_valid pulse, msg_out = 5'h15, syndrome = 3'b000, crc_ok = 1; busy falls with the pulse.
- 8'hAC (LSB flipped) -> syndrome = 3'b001, crc_ok = 0, msg_out = 5'h15. Then 8'h2D (MSB flipped) -> syndrome = 3'b001 as well (alias check).
- 8'hFE sent with random bit_valid gaps of 0-5 cycles, followed immediately by 8'h00 with its first bit arriving in the REPORT cycle -> two pulses exactly 8 accepted bits apart. First frame: msg_out = 5'h1F, crc_ok = 1. Second frame: msg_out = 0, crc_ok = 1.
- Abort with clear:
  - clear after 4 bits of 8'hAD, then a full 8'hFE -> no pulse for the aborted frame; the pulse carries msg_out = 5'h1F, crc_ok = 1.
  - clear asserted together with the 8th bit -> no pulse, and the previous outputs are unchanged.
- Reset mid-frame: rst_n low after 3 bits -> all outputs 0 immediately (asynchronous). Then a full 8'hAD -> correct report.
- CRC3_CHECKER_ERRCNT_EN defined: 3 bad frames (8'hAC) and 1 good frame -> err_count = 3. Then 300 bad frames -> err_count = 8'hFF.
